// File: rtl/id00001001_dummy_pkg.sv
// Shared definitions for the id00001001_dummy block: host access-type codes
// on conf_dbus, the processing FSM state type and the default IP identifier.
package id00001001_dummy_pkg;

  localparam logic [4:0] CONF_MEMIN   = 5'h00;
  localparam logic [4:0] CONF_MEMOUT  = 5'h01;
  localparam logic [4:0] CONF_CONFREG = 5'h02;
  localparam logic [4:0] CONF_PTR     = 5'h03;
  localparam logic [4:0] CONF_STATUS  = 5'h1E;
  localparam logic [4:0] CONF_ID      = 5'h1F;

  localparam logic [31:0] IP_ID_DEFAULT = 32'h0000_1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/id00001001_dummy_mem.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. The read register only updates when re is high, so it holds its last
// value between reads. Storage itself is not reset.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : registered read port (data valid after the read edge)
module id00001001_dummy_mem #(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/id00001001_dummy.sv
// Dummy copy engine: the host fills an input memory, sets a word count and
// pulses start; the engine copies that many words to an output memory and
// raises a sticky done interrupt. Host access is decoded from conf_dbus.
//   clk, rst_a    : clock, async active-low reset
//   en_s          : core enable; when low all state holds
//   conf_dbus     : access-type selector for read/write strobes
//   write/read    : one-cycle host strobes
//   start         : one-cycle launch pulse
//   data_in       : host write data
//   data_out      : read data, valid one cycle after the read strobe
//   int_req       : interrupt flags, bit 0 = done
module id00001001_dummy
  import id00001001_dummy_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] IP_ID     = IP_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic [4:0]        conf_dbus,
  input  logic              write,
  input  logic              read,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       int_req
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     cp_addr_q, cp_addr_d;
  logic              cp_vld_q, cp_vld_d;
  logic [DATA_W-1:0] conf_q, conf_d;
  logic [DATA_W-1:0] rd_reg_q, rd_reg_d;
  logic              rd_mem_q, rd_mem_d;
  logic              done_q, done_d;

  logic              busy;
  logic [31:0]       n_eff;
  logic [DATA_W-1:0] status;
  logic              min_we, min_re, mout_re;
  logic [DATA_W-1:0] min_rdata, mout_rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MEM_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign busy  = (state_q != ST_IDLE);
  assign n_eff = (32'(conf_q[5:0]) > 32'(MEM_DEPTH)) ? 32'(MEM_DEPTH) : 32'(conf_q[5:0]);

  always_comb begin
    status    = '0;
    status[1] = busy;
    status[0] = done_q;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    cp_addr_d = cp_addr_q;
    cp_vld_d  = cp_vld_q;
    conf_d    = conf_q;
    rd_reg_d  = rd_reg_q;
    rd_mem_d  = rd_mem_q;
    done_d    = done_q;
    min_we    = 1'b0;
    min_re    = 1'b0;
    mout_re   = 1'b0;

    if (en_s) begin
      if (write) begin
        unique case (conf_dbus)
          CONF_MEMIN: if (!busy) begin
            min_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
          end
          CONF_CONFREG: if (!busy) conf_d = data_in;
          CONF_STATUS:  if (data_in[0]) done_d = 1'b0;
          default: ;
        endcase
      end

      if (read) begin
        rd_mem_d = 1'b0;
        unique case (conf_dbus)
          CONF_MEMOUT: begin
            rd_mem_d = 1'b1;
            mout_re  = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
          end
          CONF_CONFREG: rd_reg_d = conf_q;
          CONF_STATUS:  rd_reg_d = status;
          CONF_ID:      rd_reg_d = DATA_W'(IP_ID);
          default:      rd_reg_d = '0;
        endcase
      end

      if (write && conf_dbus == CONF_PTR) begin
        wr_ptr_d = data_in[AW-1:0];
        rd_ptr_d = data_in[AW-1:0];
      end

      // The input RAM read is registered, so each copy lands in the output
      // RAM one cycle after its read; cp_vld/cp_addr carry that write.
      cp_vld_d = 1'b0;
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
          idx_d   = '0;
        end
        ST_RUN: begin
          if (n_eff == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            min_re    = 1'b1;
            cp_vld_d  = 1'b1;
            cp_addr_d = idx_q;
            if (32'(idx_q) == n_eff - 32'd1) state_d = ST_DONE;
            else                             idx_d   = idx_q + AW'(1);
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      cp_addr_q <= '0;
      cp_vld_q  <= 1'b0;
      conf_q    <= '0;
      rd_reg_q  <= '0;
      rd_mem_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      cp_addr_q <= cp_addr_d;
      cp_vld_q  <= cp_vld_d;
      conf_q    <= conf_d;
      rd_reg_q  <= rd_reg_d;
      rd_mem_q  <= rd_mem_d;
      done_q    <= done_d;
    end
  end

  id00001001_dummy_mem #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_W)) u_mem_in (
    .clk   (clk),
    .rst_n (rst_a),
    .we    (min_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (min_re),
    .raddr (idx_q),
    .rdata (min_rdata)
  );

  id00001001_dummy_mem #(.DEPTH(MEM_DEPTH), .WIDTH(DATA_W)) u_mem_out (
    .clk   (clk),
    .rst_n (rst_a),
    .we    (en_s && cp_vld_q),
    .waddr (cp_addr_q),
    .wdata (min_rdata),
    .re    (mout_re),
    .raddr (rd_ptr_q),
    .rdata (mout_rdata)
  );

  // MEMOUT reads come straight from the output RAM's read register; every
  // other read source is captured in rd_reg.
  assign data_out = rd_mem_q ? mout_rdata : rd_reg_q;
  assign int_req  = {15'b0, done_q};

endmodule

// File: tb/tb_id00001001_dummy.sv
module tb_id00001001_dummy;

  localparam logic [4:0] C_MEMIN   = 5'h00;
  localparam logic [4:0] C_MEMOUT  = 5'h01;
  localparam logic [4:0] C_CONFREG = 5'h02;
  localparam logic [4:0] C_PTR     = 5'h03;
  localparam logic [4:0] C_STATUS  = 5'h1E;
  localparam logic [4:0] C_ID      = 5'h1F;
  localparam int unsigned DEPTH    = 32;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        en_s;
  logic [4:0]  conf_dbus;
  logic        write;
  logic        read;
  logic        start;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [15:0] int_req;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory images, pointers and config register.
  logic [31:0] m_in  [DEPTH];
  logic [31:0] m_out [DEPTH];
  int unsigned m_wr;
  logic [31:0] m_conf;

  always #5 clk = ~clk;

  id00001001_dummy #(.MEM_DEPTH(32), .DATA_W(32), .IP_ID(32'h0000_1001)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .conf_dbus (conf_dbus),
    .write     (write),
    .read      (read),
    .start     (start),
    .data_in   (data_in),
    .data_out  (data_out),
    .int_req   (int_req)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] code, input logic [31:0] d);
    conf_dbus = code; data_in = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] code, output logic [31:0] d);
    conf_dbus = code; read = 1'b1;
    tick();
    read = 1'b0;
    d = data_out;
  endtask

  task automatic host_ptr(input int unsigned p);
    logic [31:0] d;
    d = $urandom;
    d[4:0] = 5'(p);
    bus_wr(C_PTR, d);
    m_wr = p;
  endtask

  task automatic host_memin(input logic [31:0] d);
    bus_wr(C_MEMIN, d);
    m_in[m_wr] = d;
    m_wr = (m_wr + 1) % DEPTH;
  endtask

  task automatic model_copy();
    int unsigned k;
    k = int'(m_conf[5:0]);
    if (k > DEPTH) k = DEPTH;
    for (int unsigned i = 0; i < k; i++) m_out[i] = m_in[i];
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!int_req[0] && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_flag", 32'(int_req[0]), 32'd1);
  endtask

  task automatic clear_done();
    bus_wr(C_STATUS, 32'h1);
    check_eq("int_cleared", 32'(int_req), 32'h0);
  endtask

  task automatic do_run(input logic [31:0] conf, input int budget);
    bus_wr(C_CONFREG, conf);
    m_conf = conf;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(budget);
    model_copy();
    clear_done();
  endtask

  task automatic check_memout(input int unsigned from);
    logic [31:0] d;
    host_ptr(from);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bus_rd(C_MEMOUT, d);
      check_eq($sformatf("memout[%0d]", (from + i) % DEPTH), d, m_out[(from + i) % DEPTH]);
    end
  endtask

  initial begin
    logic [31:0] d, conf, old;
    int unsigned p, cnt;

    rst_a = 1'b0; en_s = 1'b1; conf_dbus = '0; write = 1'b0; read = 1'b0;
    start = 1'b0; data_in = '0; m_wr = 0; m_conf = '0;
    tick(); tick();
    check_eq("rst_data_out", data_out, 32'h0);
    check_eq("rst_int_req", 32'(int_req), 32'h0);
    rst_a = 1'b1;
    tick();

    bus_rd(C_ID, d);
    check_eq("id_read", d, 32'h0000_1001);
    check_eq("id_int_req", 32'(int_req), 32'h0);
    bus_rd(C_CONFREG, d);
    check_eq("confreg_rst", d, 32'h0);
    bus_rd(5'h0A, d);
    check_eq("unmapped_read", d, 32'h0);

    // 33 writes from pointer 0: the last one wraps onto word 0.
    host_ptr(0);
    for (int i = 0; i < 33; i++) host_memin($urandom);
    check_eq("wrap_ptr_model", 32'(m_wr), 32'd1);
    do_run(32'd40, 45);
    check_memout(0);

    // Basic copy of four words with status observation.
    host_ptr(0);
    for (int i = 1; i <= 4; i++) host_memin(32'(i));
    bus_wr(C_CONFREG, 32'd4);
    m_conf = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    bus_rd(C_STATUS, d);
    check_eq("status_run", d, 32'h2);
    wait_done(5);
    model_copy();
    bus_rd(C_STATUS, d);
    check_eq("status_done", d, 32'h1);
    clear_done();
    bus_rd(C_STATUS, d);
    check_eq("status_clear", d, 32'h0);
    host_ptr(0);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(C_MEMOUT, d);
      check_eq("basic_out", d, 32'(i));
    end

    // Restart, MEMIN and CONFREG writes while busy are all ignored.
    host_ptr(0);
    for (int i = 0; i < 20; i++) host_memin($urandom);
    bus_wr(C_CONFREG, 32'd20);
    m_conf = 32'd20;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    bus_wr(C_MEMIN, $urandom);
    bus_wr(C_CONFREG, 32'd3);
    wait_done(30);
    model_copy();
    clear_done();
    bus_rd(C_CONFREG, d);
    check_eq("confreg_busy_wr", d, 32'd20);
    check_memout(0);

    // N = 0: no copy; a W1C landing on the done-set cycle loses.
    conf = $urandom;
    conf[5:0] = 6'd0;
    bus_wr(C_CONFREG, conf);
    m_conf = conf;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    bus_wr(C_STATUS, 32'h1);
    check_eq("set_wins", 32'(int_req), 32'h1);
    bus_rd(C_STATUS, d);
    check_eq("status_n0", d, 32'h1);
    clear_done();
    check_memout(5);

    // Read and write of CONFREG in the same cycle: read sees the old value.
    bus_rd(C_CONFREG, old);
    conf = $urandom;
    conf_dbus = C_CONFREG; data_in = conf; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check_eq("rw_same_cycle", data_out, old);
    bus_rd(C_CONFREG, d);
    check_eq("rw_new_value", d, conf);

    // Randomized runs from random pointers and counts.
    for (int it = 0; it < 5; it++) begin
      p = $urandom_range(0, 31);
      host_ptr(p);
      cnt = $urandom_range(1, 10);
      for (int unsigned i = 0; i < cnt; i++) host_memin($urandom);
      conf = $urandom;
      conf[5:0] = 6'($urandom_range(0, 40));
      do_run(conf, 45);
      bus_rd(C_CONFREG, d);
      check_eq("confreg_rb", d, conf);
      check_memout($urandom_range(0, 31));
    end

    // Disabled core ignores start and MEMIN writes.
    en_s = 1'b0;
    bus_wr(C_CONFREG, 32'd8);
    start = 1'b1; tick(); start = 1'b0;
    bus_wr(C_MEMIN, 32'hDEAD_BEEF);
    en_s = 1'b1;
    tick(); tick(); tick();
    bus_rd(C_STATUS, d);
    check_eq("en_off_status", d, 32'h0);
    check_eq("en_off_int", 32'(int_req), 32'h0);
    bus_rd(C_CONFREG, d);
    check_eq("en_off_conf", d, m_conf);

    // Reset in the middle of a run aborts it without raising done.
    bus_rd(C_ID, d);
    bus_wr(C_CONFREG, 32'd32);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst_a = 1'b0;
    #1;
    check_eq("midrun_rst_dout", data_out, 32'h0);
    check_eq("midrun_rst_int", 32'(int_req), 32'h0);
    tick();
    rst_a = 1'b1;
    m_wr = 0; m_conf = '0;
    tick(); tick(); tick();
    check_eq("after_rst_int", 32'(int_req), 32'h0);
    bus_rd(C_STATUS, d);
    check_eq("after_rst_status", d, 32'h0);
    do_run(32'd32, 40);
    check_memout(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
